// File: rtl/ewma_cov_sequencer_pkg.sv
// ewma_pkg: shared types and sizing helpers for the EWMA mean/covariance
// sequencer.
//   ewma_state_t   - sequencer states (IDLE, INIT, COV, MEAN, DONE)
//   n_pairs(n)     - number of upper-triangle (i <= j) pairs for an n x n matrix
//   mac_width(w)   - signed width of the shared MAC's intermediate products
package ewma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        COV,
        MEAN,
        DONE
    } ewma_state_t;

    // Headroom above 3*WIDTH so the sum of two triple products cannot overflow
    // the intermediate.
    localparam int MAC_GUARD_BITS = 2;

    function automatic int n_pairs(input int n);
        return n * (n + 1) / 2;
    endfunction

    function automatic int mac_width(input int w);
        return 3 * w + MAC_GUARD_BITS;
    endfunction

endpackage

// File: rtl/ewma_cov_sequencer_if.sv
// ewma_cov_sequencer_if: sample handshake and result bus of the EWMA
// mean/covariance sequencer.
//   valid_in / x_in / ready_in : producer offers a return vector, accepted
//                                when valid_in && ready_in
//   busy                       : an update is in progress
//   valid_out                  : one-cycle pulse, mean_out/cov_out consistent
//   mean_out / cov_out         : live working registers (signed words)
// master = producer/consumer side, slave = the sequencer.
interface ewma_cov_sequencer_if #(
    parameter int WIDTH    = 16,
    parameter int N_STOCKS = 4
);

    logic                                             valid_in;
    logic [N_STOCKS-1:0][WIDTH-1:0]                   x_in;
    logic                                             ready_in;
    logic                                             busy;
    logic                                             valid_out;
    logic [N_STOCKS-1:0][WIDTH-1:0]                   mean_out;
    logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0]     cov_out;

    modport master (
        output valid_in, x_in,
        input  ready_in, busy, valid_out, mean_out, cov_out
    );

    modport slave (
        input  valid_in, x_in,
        output ready_in, busy, valid_out, mean_out, cov_out
    );

endinterface

// File: rtl/ewma_cov_sequencer_mac.sv
// ewma_mac: shared combinational multiply-add-shift unit.
//   y = (a*b*s + c*d*e) >>> sh, all signed, evaluated in an IW-bit
//   intermediate, arithmetic (floor) shift, result wrapped to WIDTH bits.
//   a..e : OPW-bit signed operands
//   sh   : shift amount
//   y    : WIDTH-bit signed result
module ewma_mac #(
    parameter int WIDTH = 16,
    parameter int OPW   = WIDTH + 1,
    parameter int IW    = 3 * WIDTH + 2,
    parameter int SHW   = 5
) (
    input  logic signed [OPW-1:0] a,
    input  logic signed [OPW-1:0] b,
    input  logic signed [OPW-1:0] s,
    input  logic signed [OPW-1:0] c,
    input  logic signed [OPW-1:0] d,
    input  logic signed [OPW-1:0] e,
    input  logic        [SHW-1:0] sh,
    output logic signed [WIDTH-1:0] y
);

    logic signed [IW-1:0] sum;

    always_comb begin
        // Operands are sign-extended to IW before multiplying so the products
        // are formed at full intermediate width.
        sum = IW'(a) * IW'(b) * IW'(s) + IW'(c) * IW'(d) * IW'(e);
        y   = WIDTH'(sum >>> sh);
    end

endmodule

// File: rtl/ewma_cov_sequencer.sv
// ewma_cov_sequencer: time-multiplexed EWMA mean/covariance engine.
// Each accepted return vector is walked through one shared MAC: first the
// upper triangle of the covariance matrix (mirrored into the lower triangle),
// then the per-stock means. The first sample after reset only primes the
// means. Completion is signalled by a one-cycle valid_out pulse.
//   clk, rst : clock, synchronous active-high reset
//   io       : slave side of ewma_cov_sequencer_if (sample in, results out)
module ewma_cov_sequencer
    import ewma_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int FRACT    = 8,
    parameter int N_STOCKS = 4,
    parameter int LAMBDA   = 1 << (FRACT - 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    ewma_cov_sequencer_if.slave  io
);

    localparam int OPW = WIDTH + 1;                  // differences need one extra bit
    localparam int IW  = mac_width(WIDTH);
    localparam int CW  = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;
    localparam int SHW = $clog2(2 * FRACT + 1);

    localparam logic signed [OPW-1:0] ONE_OP   = OPW'(1 << FRACT);
    localparam logic signed [OPW-1:0] UNIT_OP  = OPW'(1);
    localparam logic signed [OPW-1:0] W_OLD    = OPW'((1 << FRACT) - LAMBDA);
    localparam logic signed [OPW-1:0] W_NEW    = OPW'(LAMBDA);
    localparam logic [CW-1:0]         LAST_IDX = CW'(N_STOCKS - 1);

    ewma_state_t state;
    logic        primed;
    logic        valid_q;
    logic        busy_q;
    logic        ready_q;

    logic [CW-1:0] i_q;
    logic [CW-1:0] j_q;
    logic [CW-1:0] k_q;

    logic [N_STOCKS-1:0][WIDTH-1:0]               x_q;
    logic [N_STOCKS-1:0][WIDTH-1:0]               mean_q;
    logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] cov_q;

    logic signed [OPW-1:0]   d_i;
    logic signed [OPW-1:0]   d_j;
    logic signed [OPW-1:0]   mac_a;
    logic signed [OPW-1:0]   mac_b;
    logic signed [OPW-1:0]   mac_s;
    logic signed [OPW-1:0]   mac_c;
    logic signed [OPW-1:0]   mac_d;
    logic signed [OPW-1:0]   mac_e;
    logic        [SHW-1:0]   mac_sh;
    logic signed [WIDTH-1:0] mac_y;

    // Operand mux for the shared MAC. In COV the deviations use the old means,
    // which are still untouched because the MEAN phase comes afterwards.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        mac_a  = '0;
        mac_b  = '0;
        mac_s  = '0;
        mac_c  = '0;
        mac_d  = '0;
        mac_e  = '0;
        mac_sh = '0;
        d_i    = OPW'($signed(mean_q[i_q])) - OPW'($signed(x_q[i_q]));
        d_j    = OPW'($signed(mean_q[j_q])) - OPW'($signed(x_q[j_q]));
        case (state)
            COV: begin
                // ((ONE-L)*cov*ONE + L*d_i*d_j) >>> 2*FRACT
                mac_a  = OPW'($signed(cov_q[i_q][j_q]));
                mac_b  = W_OLD;
                mac_s  = ONE_OP;
                mac_c  = d_i;
                mac_d  = d_j;
                mac_e  = W_NEW;
                mac_sh = SHW'(2 * FRACT);
            end
            MEAN: begin
                // (mean*(ONE-L) + x*L) >>> FRACT
                mac_a  = OPW'($signed(mean_q[k_q]));
                mac_b  = W_OLD;
                mac_s  = UNIT_OP;
                mac_c  = OPW'($signed(x_q[k_q]));
                mac_d  = W_NEW;
                mac_e  = UNIT_OP;
                mac_sh = SHW'(FRACT);
            end
            default: ;
        endcase
    end

    ewma_mac #(
        .WIDTH (WIDTH),
        .OPW   (OPW),
        .IW    (IW),
        .SHW   (SHW)
    ) u_mac (
        .a  (mac_a),
        .b  (mac_b),
        .s  (mac_s),
        .c  (mac_c),
        .d  (mac_d),
        .e  (mac_e),
        .sh (mac_sh),
        .y  (mac_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the working arrays are cleared by reset as well, so an
            // abandoned update leaves nothing behind and outputs read zero.
            state   <= IDLE;
            primed  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            x_q     <= '0;
            mean_q  <= '0;
            cov_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every read in this
            // block sees the value from before the edge.
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.valid_in) begin
                        x_q     <= io.x_in;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state   <= primed ? COV : INIT;
                    end
                end
                INIT: begin
                    mean_q  <= x_q;
                    cov_q   <= '0;
                    primed  <= 1'b1;
                    valid_q <= 1'b1;
                    state   <= DONE;
                end
                COV: begin
                    // Diagonal pairs write the same element twice with the
                    // same value, which is harmless.
                    cov_q[i_q][j_q] <= mac_y;
                    cov_q[j_q][i_q] <= mac_y;
                    if (j_q == LAST_IDX) begin
                        if (i_q == LAST_IDX) begin
                            state <= MEAN;
                        end else begin
                            i_q <= i_q + 1'b1;
                            j_q <= i_q + 1'b1;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                MEAN: begin
                    mean_q[k_q] <= mac_y;
                    if (k_q == LAST_IDX) begin
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign io.ready_in  = ready_q;
    assign io.busy      = busy_q;
    assign io.valid_out = valid_q;
    assign io.mean_out  = mean_q;
    assign io.cov_out   = cov_q;

endmodule
